sdf_stage_ctrl: RTL and testbench

SDF_STAGE_CTRL -- requirements
Module: sdf_stage_ctrl

---
 rtl/sdf_stage_ctrl.sv | 123 ++++++++++++
 tb/tb_sdf_stage_ctrl.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/sdf_stage_ctrl.sv
// Sequencing controller for one single-delay-feedback FFT stage: drives the
// delay line, butterfly/fill select and twiddle addressing from a sample stream.
module sdf_stage_ctrl #(
  parameter int DELAY_LEN = 16,
  parameter int CNT_W     = $clog2(2*DELAY_LEN)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             in_sof,
  input  logic             in_eof,
  output logic             in_ready,
  output logic             delay_en,
  output logic             bf_sel,
  output logic [CNT_W-2:0] tw_addr,
  output logic             tw_en,
  output logic             out_valid,
  output logic             out_sof,
  output logic             sof_err,
  output logic [1:0]       dbg_state
);

  // Handshake: a sample transfers on any cycle with in_valid & in_ready;
  // in_ready depends on state only, and drops for the D-cycle flush.
  typedef enum logic [1:0] {IDLE, FILL, RUN, FLUSH} state_t;

  localparam logic [CNT_W-1:0] D_C  = CNT_W'(DELAY_LEN);
  localparam logic [CNT_W-1:0] D_M1 = CNT_W'(DELAY_LEN - 1);
  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] fcnt;
  logic             accept;
  logic             realign;
  logic [CNT_W-1:0] idx;
  logic [CNT_W-1:0] flush_addr;

  assign in_ready   = (state != FLUSH);
  assign accept     = in_valid & in_ready & ~rst;
  // A start-of-frame inside RUN re-anchors the current sample to index 0.
  assign realign    = (state == RUN) & accept & in_sof;
  assign idx        = realign ? '0 : cnt;
  assign flush_addr = D_C - fcnt;
  assign dbg_state  = state;

  always_comb begin
    delay_en = 1'b0;
    bf_sel   = 1'b0;
    tw_en    = 1'b0;
    tw_addr  = idx[CNT_W-2:0];
    case (state)
      IDLE:  delay_en = accept & in_sof;
      FILL:  delay_en = accept;
      RUN: begin
        delay_en = accept;
        bf_sel   = idx[CNT_W-1];
        tw_en    = accept & ~idx[CNT_W-1];
      end
      FLUSH: begin
        delay_en = 1'b1;
        tw_en    = 1'b1;
        tw_addr  = flush_addr[CNT_W-2:0];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      fcnt      <= '0;
      out_valid <= 1'b0;
      out_sof   <= 1'b0;
      sof_err   <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      out_sof   <= 1'b0;
      sof_err   <= 1'b0;
      case (state)
        IDLE: begin
          if (accept && in_sof) begin
            state <= FILL;
            cnt   <= ONE;
          end
        end
        FILL: begin
          if (accept) begin
            if (cnt == D_M1) begin
              state <= RUN;
              cnt   <= D_C;
            end else begin
              cnt <= cnt + ONE;
            end
          end
        end
        RUN: begin
          if (accept) begin
            out_valid <= 1'b1;
            out_sof   <= (idx == D_C);
            sof_err   <= in_sof && (cnt != '0);
            cnt       <= idx + ONE;
            if (in_eof) begin
              state <= FLUSH;
              fcnt  <= D_C;
            end
          end
        end
        FLUSH: begin
          out_valid <= 1'b1;
          fcnt      <= fcnt - ONE;
          if (fcnt == ONE) begin
            state <= IDLE;
            cnt   <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sdf_stage_ctrl.sv
// Bench for sdf_stage_ctrl at DELAY_LEN=4: fixed vector table, corner-case
// sequences and random traffic against a frame-position reference model.
module tb_sdf_stage_ctrl;

  localparam int D     = 4;
  localparam int CNT_W = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid, in_sof, in_eof;
  logic             in_ready, delay_en, bf_sel, tw_en;
  logic [CNT_W-2:0] tw_addr;
  logic             out_valid, out_sof, sof_err;
  logic [1:0]       dbg_state;

  sdf_stage_ctrl #(.DELAY_LEN(D), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_sof(in_sof), .in_eof(in_eof),
    .in_ready(in_ready), .delay_en(delay_en), .bf_sel(bf_sel), .tw_addr(tw_addr),
    .tw_en(tw_en), .out_valid(out_valid), .out_sof(out_sof), .sof_err(sof_err),
    .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  typedef struct {
    logic       v, s, e;
    logic       rdy, de, bf, twen;
    logic [1:0] twa;
    logic       ov, osof, serr;
  } vec_t;
  vec_t tbl[14];

  // Reference model: position within the frame, whether the first half has
  // been filled, and how many flush cycles remain.
  int        m_fl;
  bit        m_in_frame, m_run;
  int        m_n;
  logic [2:0] exp_q[$];

  task automatic model_reset();
    m_fl = 0; m_in_frame = 0; m_run = 0; m_n = 0;
    exp_q.delete();
    exp_q.push_back(3'b000);
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b1; in_sof = 1'b1; in_eof = 1'b0;
    #2;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_delay_en", delay_en, 0);
    chk("rst_bf_sel", bf_sel, 0);
    chk("rst_tw_en", tw_en, 0);
    chk("rst_tw_addr", tw_addr, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_sof", out_sof, 0);
    chk("rst_sof_err", sof_err, 0);
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0; in_sof = 1'b0;
    model_reset();
  endtask

  task automatic cycle(input logic v, input logic s, input logic e);
    logic [2:0] r;
    bit e_rdy, e_de, e_bf, e_twen, nov, nos, nse;
    int e_twa, idx;
    in_valid = v; in_sof = s; in_eof = e;
    @(negedge clk);
    if (exp_q.size() == 0) chk("scoreboard_empty", 1, 0);
    else begin
      r = exp_q.pop_front();
      chk("out_valid", out_valid, r[2]);
      chk("out_sof", out_sof, r[1]);
      chk("sof_err", sof_err, r[0]);
    end
    e_rdy = 1; e_de = 0; e_bf = 0; e_twen = 0; e_twa = 0;
    nov = 0; nos = 0; nse = 0;
    if (m_fl > 0) begin
      e_rdy = 0; e_de = 1; e_twen = 1; e_twa = D - m_fl; nov = 1;
      m_fl--;
      if (m_fl == 0) m_in_frame = 0;
    end else if (v) begin
      if (!m_in_frame) begin
        if (s) begin m_in_frame = 1; m_run = 0; m_n = 1; e_de = 1; end
      end else if (!m_run) begin
        e_de = 1; e_twa = m_n % D;
        m_n++;
        if (m_n == D) m_run = 1;
      end else begin
        idx = s ? 0 : m_n;
        e_de = 1; e_bf = (idx >= D); e_twa = idx % D; e_twen = (idx < D);
        nov = 1; nos = (idx == D); nse = s && (m_n != 0);
        m_n = (idx + 1) % (2 * D);
        if (e) m_fl = D;
      end
    end
    exp_q.push_back({nov, nos, nse});
    chk("in_ready", in_ready, e_rdy);
    chk("delay_en", delay_en, e_de);
    chk("tw_en", tw_en, e_twen);
    if (e_de) begin
      chk("bf_sel", bf_sel, e_bf);
      chk("tw_addr", tw_addr, e_twa);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    tbl[0]  = '{1,1,0, 1,1,0,0,2'd0, 0,0,0};
    tbl[1]  = '{1,0,0, 1,1,0,0,2'd1, 0,0,0};
    tbl[2]  = '{1,0,0, 1,1,0,0,2'd2, 0,0,0};
    tbl[3]  = '{1,0,0, 1,1,0,0,2'd3, 0,0,0};
    tbl[4]  = '{1,0,0, 1,1,1,0,2'd0, 0,0,0};
    tbl[5]  = '{1,0,0, 1,1,1,0,2'd1, 1,1,0};
    tbl[6]  = '{1,0,0, 1,1,1,0,2'd2, 1,0,0};
    tbl[7]  = '{1,0,1, 1,1,1,0,2'd3, 1,0,0};
    tbl[8]  = '{1,0,0, 0,1,0,1,2'd0, 1,0,0};
    tbl[9]  = '{1,0,0, 0,1,0,1,2'd1, 1,0,0};
    tbl[10] = '{0,0,0, 0,1,0,1,2'd2, 1,0,0};
    tbl[11] = '{0,0,0, 0,1,0,1,2'd3, 1,0,0};
    tbl[12] = '{0,0,0, 1,0,0,0,2'd0, 1,0,0};
    tbl[13] = '{0,0,0, 1,0,0,0,2'd0, 0,0,0};

    do_reset();
    for (int i = 0; i < 14; i++) begin
      in_valid = tbl[i].v; in_sof = tbl[i].s; in_eof = tbl[i].e;
      @(negedge clk);
      chk($sformatf("tbl%0d_in_ready", i), in_ready, tbl[i].rdy);
      chk($sformatf("tbl%0d_delay_en", i), delay_en, tbl[i].de);
      chk($sformatf("tbl%0d_tw_en", i), tw_en, tbl[i].twen);
      if (tbl[i].de) begin
        chk($sformatf("tbl%0d_bf_sel", i), bf_sel, tbl[i].bf);
        chk($sformatf("tbl%0d_tw_addr", i), tw_addr, tbl[i].twa);
      end
      chk($sformatf("tbl%0d_out_valid", i), out_valid, tbl[i].ov);
      chk($sformatf("tbl%0d_out_sof", i), out_sof, tbl[i].osof);
      chk($sformatf("tbl%0d_sof_err", i), sof_err, tbl[i].serr);
      @(posedge clk); #1;
    end

    // 16 contiguous samples: counter wraps into the second frame, then flush.
    do_reset();
    for (int i = 0; i < 16; i++) cycle(1'b1, i == 0, i == 15);
    for (int i = 0; i < 6; i++) cycle(1'b0, 1'b0, 1'b0);

    // Three-cycle gaps between every sample.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      cycle(1'b1, i == 0, 1'b0);
      for (int g = 0; g < 3; g++) cycle(1'b0, 1'b0, 1'b0);
    end

    // Misaligned start-of-frame on sample 6.
    do_reset();
    for (int i = 0; i < 6; i++) cycle(1'b1, i == 0, 1'b0);
    cycle(1'b1, 1'b1, 1'b0);
    chk("misalign_sof_err_pulse", sof_err, 1);
    cycle(1'b1, 1'b0, 1'b0);
    chk("misalign_sof_err_once", sof_err, 0);
    cycle(1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 6; i++) cycle(1'b0, 1'b0, 1'b0);

    // Asynchronous reset in the middle of a flush.
    do_reset();
    for (int i = 0; i < 8; i++) cycle(1'b1, i == 0, i == 7);
    cycle(1'b0, 1'b0, 1'b0);
    chk("midflush_out_valid_before", out_valid, 1);
    rst = 1'b1;
    #2;
    chk("midflush_rst_out_valid", out_valid, 0);
    chk("midflush_rst_in_ready", in_ready, 1);
    chk("midflush_rst_delay_en", delay_en, 0);
    #1 rst = 1'b0;
    model_reset();
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 1'b0);

    // Random traffic.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      logic v, s, e;
      v = ($urandom_range(0, 9) < 7);
      s = ($urandom_range(0, 99) < (m_in_frame ? 3 : 30));
      e = ($urandom_range(0, 99) < 3);
      cycle(v, s, e);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
